fb_fill_ctrl: RTL
=================

# fb_fill_ctrl

Frame-buffer write controller. It shares the single frame-buffer write port between direct CPU pixel writes and a hardware rectangle-fill engine. It sits in the CPU clock domain, between the CPU memory-mapped bus and the frame buffer's write port (Port A). It drives write-enable, address and 12-bit colour, filling one pixel per cycle whenever the CPU is not writing.

## Interface
Parameters:
- FB_WIDTH, 320, frame-buffer width in pixels
- FB_HEIGHT, 240, frame-buffer height in pixels

Ports:
- clk  in  1  clock; all logic is in this single clock domain
- reset_n  in  1  asynchronous active-low reset
- cpu_we  in  1  CPU direct pixel write strobe
- cpu_addr  in  17  CPU pixel address
- cpu_wdata  in  12  CPU pixel colour {R,G,B}
- cmd_valid  in  1  fill command valid
- cmd_ready  out  1  controller can accept a command
- cmd_x  in  9  rectangle left column
- cmd_y  in  8  rectangle top row
- cmd_w  in  9  rectangle width (0 allowed)
- cmd_h  in  8  rectangle height (0 allowed)
- cmd_color  in  12  fill colour
- busy  out  1  a command is in progress (SETUP/FILL/DONE)
- done  out  1  one-cycle pulse when a command retires
- err  out  1  one-cycle pulse, coincident with done, when a command is rejected (clip disabled only)
- fb_we  out  1  frame-buffer write enable
- fb_addr  out  17  frame-buffer write address
- fb_wdata  out  12  frame-buffer write data

## Operation
- FSM states: IDLE, SETUP, FILL, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch the command and go to SETUP.
- SETUP, one cycle:
  - Compute clipped bounds in 10-bit arithmetic: xe=min(x+w, FB_WIDTH), ye=min(y+h, FB_HEIGHT).
  - Compute row_base=y*FB_WIDTH (17 bits).
  - The rectangle is empty if w==0, h==0, x>=FB_WIDTH or y>=FB_HEIGHT; an empty rectangle goes to DONE.
  - Otherwise go to FILL with cur_x=x, cur_y=y.
- FILL:
  - Each cycle with cpu_we=0: emit a write at row_base+cur_x with cmd_color, then increment cur_x.
  - At cur_x==xe-1: set cur_x=x, cur_y+=1, row_base+=FB_WIDTH.
  - After the write at (xe-1, ye-1): go to DONE.
- DONE:
  - Pulse done (and err if the command was rejected); go to IDLE.
- Arbitration:
  - cpu_we has absolute priority. In a cycle with cpu_we=1, the CPU write is forwarded and the fill position does not advance.
  - CPU writes are forwarded in every state.
- Write-port behaviour:
  - Exactly one write per cycle at most.
  - The CPU and fill paths never emit in the same cycle.
  - Pixel order within a command is row-major, left to right.
- Reset (asynchronous, including mid-fill):
  - Outputs: fb_we=0, fb_addr=0, fb_wdata=0, done=0, err=0, busy=0, cmd_ready=1.
  - FSM returns to IDLE; any partial fill is abandoned.

## Timing
- fb_we, fb_addr and fb_wdata are registered: a CPU write presented in cycle N appears on the port in cycle N+1.
- Command handshake: the command transfers on the cycle where cmd_valid and cmd_ready are both 1. cmd_ready drops the next cycle and stays low until the cycle after DONE.
- Command latency (from the handshake cycle):
  - SETUP occupies cycle +1.
  - The first fill write appears at cycle +3.
  - For P clipped pixels and S stall cycles, the last write appears at cycle +2+P+S.
  - done pulses in the cycle after the last write.
- Empty rectangle: done pulses at cycle +3 with no writes.
- Throughput: 1 pixel/cycle when the CPU is idle.
- busy is high from the cycle after the handshake until the cycle after DONE, inclusive of DONE.

## Configuration
- FB_FILL_CLIP_EN defined:
  - Rectangles extending past FB_WIDTH/FB_HEIGHT are clipped to the screen.
  - err is tied to 0.
- FB_FILL_CLIP_EN undefined:
  - SETUP rejects any command with x+w>FB_WIDTH or y+h>FB_HEIGHT.
  - A rejected command goes to DONE with no writes and pulses done and err together.
  - Empty in-range commands complete with err=0.

## Test plan
- Fill, no CPU traffic: x=10, y=2, w=3, h=2, colour 0xF00 -> six writes at addr 650, 651, 652, 970, 971, 972, all data 0xF00, on consecutive cycles; then done at +9.
- CPU contention: same command plus cpu_we=1 with addr 5, data 0x0F0 during the 2nd fill cycle -> port shows 650, 5(0x0F0), 651, 652, 970, 971, 972; done delayed by one cycle.
- Clip (macro defined): x=318, y=239, w=5, h=5 -> writes at 76798 and 76799 only; done, err=0. Macro undefined: no writes, done and err pulse together.
- Zero-size: w=0, h=4 -> no fb_we, done at handshake+3, cmd_ready high again the following cycle.
- Reset mid-fill: a 100x100 fill with reset_n asserted after 20 writes -> fb_we=0 and busy=0 immediately, cmd_ready=1 after release, no further writes.
- Back-to-back: cmd_valid held high with two commands -> second handshake only after the first done; no write gap beyond SETUP/DONE.

Source files
------------

// File: rtl/fb_fill_ctrl.sv
// Frame-buffer write-port controller: forwards CPU pixel writes and runs a rectangle-fill engine in idle slots.
// Write port registered (1 cycle); CPU write always wins; FB_FILL_CLIP_EN clips oversize rectangles instead of rejecting them.
module fb_fill_ctrl #(
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 240
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_we,
  input  logic [16:0] cpu_addr,
  input  logic [11:0] cpu_wdata,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  input  logic [8:0]  cmd_w,
  input  logic [7:0]  cmd_h,
  input  logic [11:0] cmd_color,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        fb_we,
  output logic [16:0] fb_addr,
  output logic [11:0] fb_wdata
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_DONE} state_t;

  localparam logic [9:0]  LP_W10 = 10'(FB_WIDTH);
  localparam logic [9:0]  LP_H10 = 10'(FB_HEIGHT);
  localparam logic [16:0] LP_W17 = 17'(FB_WIDTH);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [8:0]  r_x;
  logic [7:0]  r_y;
  logic [8:0]  r_w;
  logic [7:0]  r_h;
  logic [11:0] r_color;
  logic [9:0]  r_xe;
  logic [9:0]  r_ye;
  logic [9:0]  r_cur_x;
  logic [9:0]  r_cur_y;
  logic [16:0] r_row_base;
  logic        r_rej;

  logic        r_fb_we;
  logic [16:0] r_fb_addr;
  logic [11:0] r_fb_wdata;
  logic        r_done;
  logic        r_err;

  logic [9:0]  w_xsum;
  logic [9:0]  w_ysum;
  logic [9:0]  w_xe;
  logic [9:0]  w_ye;
  logic        w_empty;
  logic        w_rej;
  logic        w_last_col;
  logic        w_last_row;
  logic        w_fill_we;
  logic        w_cmd_ready;
  logic        w_busy;

  // Bounds in 10 bits so x+w and y+h never wrap
  assign w_xsum  = 10'(r_x) + 10'(r_w);
  assign w_ysum  = 10'(r_y) + 10'(r_h);
  assign w_xe    = (w_xsum > LP_W10) ? LP_W10 : w_xsum;
  assign w_ye    = (w_ysum > LP_H10) ? LP_H10 : w_ysum;
  assign w_empty = (r_w == 9'd0) || (r_h == 8'd0) ||
                   (10'(r_x) >= LP_W10) || (10'(r_y) >= LP_H10);
`ifdef FB_FILL_CLIP_EN
  assign w_rej   = 1'b0;
`else
  assign w_rej   = (w_xsum > LP_W10) || (w_ysum > LP_H10);
`endif

  assign w_last_col = (r_cur_x == r_xe - 10'd1);
  assign w_last_row = (r_cur_y == r_ye - 10'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fill_we   = 1'b0;
    w_cmd_ready = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        w_busy      = 1'b0;
        if (cmd_valid) begin
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        w_state_nxt = (w_empty || w_rej) ? S_DONE : S_FILL;
      end
      S_FILL: begin
        // A CPU write steals the slot; the fill position holds
        if (!cpu_we) begin
          w_fill_we = 1'b1;
          if (w_last_col && w_last_row) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_color    <= '0;
      r_xe       <= '0;
      r_ye       <= '0;
      r_cur_x    <= '0;
      r_cur_y    <= '0;
      r_row_base <= '0;
      r_rej      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_x     <= cmd_x;
            r_y     <= cmd_y;
            r_w     <= cmd_w;
            r_h     <= cmd_h;
            r_color <= cmd_color;
          end
        end
        S_SETUP: begin
          r_xe       <= w_xe;
          r_ye       <= w_ye;
          r_cur_x    <= 10'(r_x);
          r_cur_y    <= 10'(r_y);
          r_row_base <= 17'(r_y) * LP_W17;
          r_rej      <= w_rej;
        end
        S_FILL: begin
          if (w_fill_we) begin
            if (w_last_col) begin
              r_cur_x    <= 10'(r_x);
              r_cur_y    <= r_cur_y + 10'd1;
              r_row_base <= r_row_base + LP_W17;
            end else begin
              r_cur_x <= r_cur_x + 10'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fb_we    <= 1'b0;
      r_fb_addr  <= '0;
      r_fb_wdata <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_fb_we <= cpu_we | w_fill_we;
      if (cpu_we) begin
        r_fb_addr  <= cpu_addr;
        r_fb_wdata <= cpu_wdata;
      end else if (w_fill_we) begin
        r_fb_addr  <= r_row_base + 17'(r_cur_x);
        r_fb_wdata <= r_color;
      end
      r_done <= (r_state == S_DONE);
      r_err  <= (r_state == S_DONE) && r_rej;
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign busy      = w_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign fb_we     = r_fb_we;
  assign fb_addr   = r_fb_addr;
  assign fb_wdata  = r_fb_wdata;

endmodule
